// File: rtl/axis_bit_corr_prog.sv
// Programmable +1/-1 tap correlator for NUM_PARALLEL time-multiplexed AXI-Stream channels.
// One channel is evaluated per cycle; each result is saturated and compared against a peak threshold.
module axis_bit_corr_prog #(
    parameter int NUM_PARALLEL = 8,
    parameter int PRECISION    = 6,
    parameter int WAVE_WIDTH   = 8,
    parameter int MAX_LENGTH   = 16,
    parameter int ADDER_WIDTH  = 12,
    parameter int FILT_WIDTH   = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 s_axis_tvalid,
    output logic                                 s_axis_tready,
    input  logic [NUM_PARALLEL*WAVE_WIDTH-1:0]   s_axis_tdata,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic [NUM_PARALLEL*FILT_WIDTH-1:0]   m_axis_tdata,
    output logic [NUM_PARALLEL-1:0]              m_axis_tuser,
    input  logic                                 cfg_valid,
    output logic                                 cfg_ready,
    input  logic [MAX_LENGTH-1:0]                cfg_coef,
    input  logic [$clog2(MAX_LENGTH):0]          cfg_length,
    input  logic [FILT_WIDTH-1:0]                cfg_threshold
);
    localparam int CW = $clog2(NUM_PARALLEL);
    localparam int LW = $clog2(MAX_LENGTH) + 1;
    localparam int WW = ((ADDER_WIDTH > FILT_WIDTH) ? ADDER_WIDTH : FILT_WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CH = CW'(NUM_PARALLEL - 1);
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] LEN_ONE = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] MAX_LEN = LW'(MAX_LENGTH);
    localparam logic signed [WW-1:0] F_MAX = {{(WW-FILT_WIDTH+1){1'b0}}, {(FILT_WIDTH-1){1'b1}}};
    localparam logic signed [WW-1:0] F_MIN = {{(WW-FILT_WIDTH+1){1'b1}}, {(FILT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROC = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Clamp the adder result into the signed output range (plain sign extension when it fits).
    function automatic logic [FILT_WIDTH-1:0] sat_fn(input logic signed [ADDER_WIDTH-1:0] v);
        logic signed [WW-1:0] w;
        w = WW'(v);
        if (w > F_MAX) begin
            return F_MAX[FILT_WIDTH-1:0];
        end else if (w < F_MIN) begin
            return F_MIN[FILT_WIDTH-1:0];
        end else begin
            return w[FILT_WIDTH-1:0];
        end
    endfunction

    // One extra bit so the magnitude of the most negative value is representable.
    function automatic logic [FILT_WIDTH:0] mag_fn(input logic [FILT_WIDTH-1:0] y);
        logic [FILT_WIDTH:0] e;
        e = {y[FILT_WIDTH-1], y};
        if (y[FILT_WIDTH-1]) begin
            return (~e) + {{FILT_WIDTH{1'b0}}, 1'b1};
        end else begin
            return e;
        end
    endfunction

    state_t                          state_r;
    state_t                          state_s;
    logic                            idle_r;
    logic [CW-1:0]                   cnt_r;
    logic [MAX_LENGTH-1:0]           coef_r;
    logic [LW-1:0]                   len_r;
    logic [LW-1:0]                   len_s;
    logic [FILT_WIDTH-1:0]           thr_r;
    logic signed [PRECISION-1:0]     hist_r [NUM_PARALLEL][MAX_LENGTH];
    logic [FILT_WIDTH-1:0]           y_r [NUM_PARALLEL];
    logic [NUM_PARALLEL-1:0]         tuser_r;
    logic                            tvalid_r;
    logic signed [ADDER_WIDTH-1:0]   acc_s;
    logic [FILT_WIDTH-1:0]           y_s;
    logic                            flag_s;
    logic                            s_fire_s;
    logic                            cfg_fire_s;
    logic                            unused_bits_s;

    // idle_r is held low through reset so neither stream is offered until the first clean edge.
    assign cfg_ready     = idle_r;
    assign s_axis_tready = idle_r & ~cfg_valid;
    assign s_fire_s      = s_axis_tvalid & s_axis_tready;
    assign cfg_fire_s    = cfg_valid & cfg_ready;
    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tuser  = tuser_r;
    assign unused_bits_s = ^s_axis_tdata;

    for (genvar c = 0; c < NUM_PARALLEL; c++) begin : g_pack
        assign m_axis_tdata[c*FILT_WIDTH +: FILT_WIDTH] = y_r[c];
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (s_fire_s) begin
                    state_s = PROC;
                end else begin
                    state_s = IDLE;
                end
            end
            PROC: begin
                if (cnt_r == LAST_CH) begin
                    state_s = OUT;
                end else begin
                    state_s = PROC;
                end
            end
            OUT: begin
                if (m_axis_tready) begin
                    state_s = IDLE;
                end else begin
                    state_s = OUT;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Normalise the requested tap count into 1..MAX_LENGTH.
    always_comb begin
        len_s = cfg_length;
        if (cfg_length == '0) begin
            len_s = LEN_ONE;
        end else if (cfg_length > MAX_LEN) begin
            len_s = MAX_LEN;
        end else begin
            len_s = cfg_length;
        end
    end

    // Correlate the history of the channel selected by cnt_r, then saturate and flag it.
    always_comb begin
        acc_s = '0;
        for (int j = 0; j < MAX_LENGTH; j++) begin
            if (j < 32'(len_r)) begin
                if (coef_r[j]) begin
                    acc_s = acc_s + ADDER_WIDTH'(hist_r[cnt_r][j]);
                end else begin
                    acc_s = acc_s - ADDER_WIDTH'(hist_r[cnt_r][j]);
                end
            end else begin
                acc_s = acc_s;
            end
        end
        y_s    = sat_fn(acc_s);
        flag_s = (thr_r != '0) && (mag_fn(y_s) >= {1'b0, thr_r});
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Handshake flags and channel counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_r   <= 1'b0;
            tvalid_r <= 1'b0;
            cnt_r    <= '0;
        end else begin
            idle_r   <= (state_s == IDLE);
            tvalid_r <= (state_s == OUT);
            if (state_r == PROC) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= '0;
            end
        end
    end

    // Coefficient, length and threshold registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coef_r <= '1;
            len_r  <= MAX_LEN;
            thr_r  <= '0;
        end else if (cfg_fire_s) begin
            coef_r <= cfg_coef;
            len_r  <= len_s;
            thr_r  <= cfg_threshold;
        end
    end

    // Sample history: cleared on reset or reconfiguration, shifted only on accepted beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_PARALLEL; c++) begin
                for (int j = 0; j < MAX_LENGTH; j++) begin
                    hist_r[c][j] <= '0;
                end
            end
        end else if (cfg_fire_s) begin
            for (int c = 0; c < NUM_PARALLEL; c++) begin
                for (int j = 0; j < MAX_LENGTH; j++) begin
                    hist_r[c][j] <= '0;
                end
            end
        end else if (s_fire_s) begin
            for (int c = 0; c < NUM_PARALLEL; c++) begin
                hist_r[c][0] <= s_axis_tdata[c*WAVE_WIDTH +: PRECISION];
                for (int j = 1; j < MAX_LENGTH; j++) begin
                    hist_r[c][j] <= hist_r[c][j-1];
                end
            end
        end
    end

    // Result lanes, written one channel per PROC cycle and frozen while OUT stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_PARALLEL; c++) begin
                y_r[c] <= '0;
            end
            tuser_r <= '0;
        end else if (state_r == PROC) begin
            y_r[cnt_r]     <= y_s;
            tuser_r[cnt_r] <= flag_s;
        end
    end
endmodule
